spart_bus_if: RTL and testbench

Parametrised processor-side bus interface for the SPART, superseding the single-register databus block. It decodes `iocs`/`iorw`/`ioaddr` from the processor, buffers transmit and receive characters in DEPTH-entry FIFOs, exposes a status register and the baud-divisor registers, and hands characters to and from the SPART TX and RX engines by valid/ready handshakes. It sits between the processor's I/O bus and the SPART baud generator and TX/RX engines.

---
 rtl/spart_bus_if.sv | 146 ++++++++++++++
 tb/tb_spart_bus_if.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_if.sv
// SPART processor-side bus interface: register decode, TX/RX character FIFOs,
// status flags and baud divisor registers with valid/ready engine handshakes.

module spart_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o,
    output logic [$clog2(DEPTH):0]   cnt_o,
    output logic [$clog2(DEPTH):0]   cnt_d_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_i)  rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;
endmodule

module spart_bus_if #(
    parameter int          DW        = 8,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd325
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iocs,
    input  logic          iorw,
    input  logic [1:0]    ioaddr,
    inout  wire  [DW-1:0] databus,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [15:0]   divisor,
    output logic          divisor_load,
    output logic          rda,
    output logic          tbr,
    output logic          rx_overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic          bus_rd, bus_wr;
    logic          rx_push, rx_pop, tx_push, tx_pop;
    logic [DW-1:0] rx_head, tx_head, rd_data;
    logic [AW:0]   rx_cnt, rx_cnt_d, tx_cnt, tx_cnt_d;
    logic          rda_q, tbr_q, ovr_q, dload_q;
    logic [15:0]   div_q;
    logic [7:0]    stg_q;

    assign bus_rd = iocs & iorw;
    assign bus_wr = iocs & ~iorw;

    // A full FIFO still accepts a push when it is popped in the same cycle.
    assign rx_pop  = bus_rd & (ioaddr == 2'b00) & (rx_cnt != '0);
    assign rx_push = rx_valid & ((rx_cnt != FULL) | rx_pop);
    assign tx_pop  = tx_valid & tx_ready;
    assign tx_push = bus_wr & (ioaddr == 2'b00) & ((tx_cnt != FULL) | tx_pop);

    spart_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .wdata_i(rx_data),
        .rdata_o(rx_head), .cnt_o(rx_cnt), .cnt_d_o(rx_cnt_d)
    );

    spart_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .wdata_i(databus),
        .rdata_o(tx_head), .cnt_o(tx_cnt), .cnt_d_o(tx_cnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rda_q   <= 1'b0;
            tbr_q   <= 1'b1;
            ovr_q   <= 1'b0;
            dload_q <= 1'b0;
            div_q   <= DIV_RESET;
            stg_q   <= DIV_RESET[7:0];
        end else begin
            rda_q   <= (rx_cnt_d != '0);
            tbr_q   <= (tx_cnt_d != FULL);
            dload_q <= bus_wr & (ioaddr == 2'b11);
            // A dropped character in the same cycle as a status read keeps the flag set.
            if (rx_valid & ~rx_push)
                ovr_q <= 1'b1;
            else if (bus_rd & (ioaddr == 2'b01))
                ovr_q <= 1'b0;
            if (bus_wr & (ioaddr == 2'b10)) stg_q <= databus[7:0];
            if (bus_wr & (ioaddr == 2'b11)) div_q <= {databus[7:0], stg_q};
        end
    end

    always_comb begin
        rd_data = '0;
        case (ioaddr)
            2'b00:   rd_data = (rx_cnt != '0) ? rx_head : '0;
            2'b01:   rd_data[3:0] = {tx_cnt == '0, ovr_q, rda_q, tbr_q};
            2'b10:   rd_data[7:0] = div_q[7:0];
            default: rd_data[7:0] = div_q[15:8];
        endcase
    end

    assign databus      = bus_rd ? rd_data : {DW{1'bz}};
    assign tx_valid     = (tx_cnt != '0);
    assign tx_data      = tx_valid ? tx_head : '0;
    assign divisor      = div_q;
    assign divisor_load = dload_q;
    assign rda          = rda_q;
    assign tbr          = tbr_q;
    assign rx_overrun   = ovr_q;
endmodule

// File: tb/tb_spart_bus_if.sv
// Bench for spart_bus_if: directed scenarios with literal expectations plus a
// queue-based reference model compared against the DUT on every falling edge.

module tb_spart_bus_if;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          iocs = 1'b0, iorw = 1'b0;
    logic [1:0]    ioaddr = 2'b00;
    wire  [DW-1:0] databus;
    logic          drv_en = 1'b0;
    logic [DW-1:0] drv_val = '0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [15:0]   divisor;
    logic          divisor_load, rda, tbr, rx_overrun;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] last_rd;

    assign databus = drv_en ? drv_val : {DW{1'bz}};

    spart_bus_if #(.DW(DW), .DEPTH(DEPTH), .DIV_RESET(16'd325)) dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .divisor(divisor), .divisor_load(divisor_load), .rda(rda), .tbr(tbr),
        .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic hiz(input logic [DW-1:0] v);
        return (v === {DW{1'bz}}) || (v === {DW{1'b0}});
    endfunction

    // Reference model: plain queues and scalars updated by the access rules.
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] txq[$];
    logic          m_ovr, m_dl;
    logic [15:0]   m_div;
    logic [7:0]    m_stg;

    function automatic logic [DW-1:0] exp_rd(input logic [1:0] a);
        logic [DW-1:0] v;
        v = '0;
        case (a)
            2'b00: if (rxq.size() != 0) v = rxq[0];
            2'b01: v[3:0] = {txq.size() == 0, m_ovr, rxq.size() != 0, txq.size() < DEPTH};
            2'b10: v[7:0] = m_div[7:0];
            default: v[7:0] = m_div[15:8];
        endcase
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rxq.delete();
            txq.delete();
            m_ovr = 1'b0;
            m_dl  = 1'b0;
            m_div = 16'd325;
            m_stg = 8'h45;
        end else begin
            logic rd, wr, rxpop, txpop, rxok, txok;
            rd    = iocs & iorw;
            wr    = iocs & ~iorw;
            rxpop = rd && ioaddr == 2'b00 && rxq.size() != 0;
            txpop = txq.size() != 0 && tx_ready;
            rxok  = rx_valid && (rxq.size() < DEPTH || rxpop);
            txok  = wr && ioaddr == 2'b00 && (txq.size() < DEPTH || txpop);
            if (rxpop) void'(rxq.pop_front());
            if (txpop) void'(txq.pop_front());
            if (rxok) rxq.push_back(rx_data);
            if (txok) txq.push_back(databus);
            if (rx_valid && !rxok) m_ovr = 1'b1;
            else if (rd && ioaddr == 2'b01) m_ovr = 1'b0;
            m_dl = wr && ioaddr == 2'b11;
            if (wr && ioaddr == 2'b11) m_div = {databus[7:0], m_stg};
            if (wr && ioaddr == 2'b10) m_stg = databus[7:0];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("tx_valid", tx_valid, txq.size() != 0);
            chk("tx_data", tx_data, (txq.size() != 0) ? txq[0] : '0);
            chk("rda", rda, rxq.size() != 0);
            chk("tbr", tbr, txq.size() < DEPTH);
            chk("rx_overrun", rx_overrun, m_ovr);
            chk("divisor", divisor, m_div);
            chk("divisor_load", divisor_load, m_dl);
            if (iocs && iorw)  chk("bus_read", databus, exp_rd(ioaddr));
            else if (drv_en)   chk("bus_write_undisturbed", databus, drv_val);
            else               chk("bus_hiz", hiz(databus), 1'b1);
        end
    end

    // One bus cycle, starting and ending just after a rising edge.
    task automatic step(input logic cs, input logic rw, input logic [1:0] a,
                        input logic [7:0] d, input logic rv, input logic [7:0] rd);
        iocs = cs; iorw = rw; ioaddr = a;
        drv_en = cs & ~rw; drv_val = DW'(d);
        rx_valid = rv; rx_data = DW'(rd);
        @(negedge clk);
        last_rd = databus;
        @(posedge clk);
        #1;
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; drv_en = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic bwr(input logic [1:0] a, input logic [7:0] d); step(1, 0, a, d, 0, 0); endtask
    task automatic brd(input logic [1:0] a); step(1, 1, a, 0, 0, 0); endtask
    task automatic rxp(input logic [7:0] d); step(0, 0, 0, 0, 1, d); endtask
    task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        ioaddr = 2'b10;
        #2 rst = 1'b1;
        #1;
        chk("rst_bus_hiz", hiz(databus), 1'b1);
        chk("rst_divisor", divisor, 16'd325);
        chk("rst_tbr", tbr, 1'b1);
        chk("rst_rda", rda, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_overrun", rx_overrun, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        ioaddr = 2'b00;

        // TX fill and drain.
        for (int i = 1; i <= 4; i++) begin
            bwr(2'b00, 8'(8'h11 * i));
            chk("tx_fill_tbr", tbr, i < 4);
        end
        bwr(2'b00, 8'h55);
        chk("tx_full_head", tx_data, 8'h11);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("tx_drain_data", tx_data, 8'(8'h11 * i));
            idle();
        end
        tx_ready = 1'b0;
        chk("tx_drained_valid", tx_valid, 1'b0);
        chk("tx_drained_tbr", tbr, 1'b1);

        // RX overrun.
        for (int i = 0; i < 5; i++) rxp(8'(8'hA0 + i));
        chk("rx_ovr_set", rx_overrun, 1'b1);
        for (int i = 0; i < 4; i++) begin
            brd(2'b00);
            chk("rx_read", last_rd, 8'(8'hA0 + i));
        end
        brd(2'b00);
        chk("rx_read_empty", last_rd, 8'h00);
        brd(2'b01);
        chk("status_ovr", last_rd, 8'h0D);
        brd(2'b01);
        chk("status_clear", last_rd, 8'h09);

        // RX full with simultaneous pop and push.
        for (int i = 0; i < 4; i++) rxp(8'(8'hB0 + i));
        step(1, 1, 2'b00, 0, 1, 8'hB5);
        chk("rx_full_pop_head", last_rd, 8'hB0);
        chk("rx_full_no_ovr", rx_overrun, 1'b0);
        chk("rx_full_rda", rda, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            brd(2'b00);
            chk("rx_after_swap", last_rd, (i < 4) ? 8'(8'hB0 + i) : 8'hB5);
        end

        // Divisor registers.
        bwr(2'b10, 8'h8B);
        chk("div_low_only", divisor, 16'd325);
        bwr(2'b11, 8'h02);
        chk("div_written", divisor, 16'h028B);
        chk("div_load_pulse", divisor_load, 1'b1);
        idle();
        chk("div_load_drop", divisor_load, 1'b0);
        brd(2'b10);
        chk("div_rd_low", last_rd, 8'h8B);
        brd(2'b11);
        chk("div_rd_high", last_rd, 8'h02);
        bwr(2'b10, 8'h77);
        chk("div_lone_low", divisor, 16'h028B);

        // Reset mid-operation.
        bwr(2'b00, 8'h5A);
        rxp(8'hC3);
        ioaddr = 2'b10;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_rda", rda, 1'b0);
        chk("mid_rst_divisor", divisor, 16'd325);
        chk("mid_rst_bus_hiz", hiz(databus), 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        ioaddr = 2'b00;
        bwr(2'b11, 8'h01);
        chk("staging_reset", divisor, 16'h0145);

        // Random traffic; the falling-edge compare process checks every cycle.
        for (int n = 0; n < 10000; n++) begin
            iocs     = ($urandom_range(0, 1) == 1);
            iorw     = ($urandom_range(0, 1) == 1);
            ioaddr   = 2'($urandom_range(0, 3));
            drv_en   = iocs & ~iorw;
            drv_val  = DW'($urandom);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = DW'($urandom);
            tx_ready = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
        iocs = 1'b0; drv_en = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
